// File: rtl/lp_stream_tx.sv
// lp_stream_tx: loads one LP problem (objective + 6 constraints) and streams it to the solver.
// Optional macro LP_TX_TIMEOUT_EN bounds the wait for the solver result by WAIT_MAX cycles.
module lp_stream_tx #(
  parameter int LAT_W    = 16,
  parameter int WAIT_MAX = 4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_addr,
  input  logic [5:0]        cfg_a1,
  input  logic [5:0]        cfg_a2,
  input  logic [11:0]       cfg_b,
  input  logic              start,
  output logic              busy,
  output logic              in_valid,
  output logic [5:0]        in_a1,
  output logic [5:0]        in_a2,
  output logic [11:0]       in_b,
  input  logic              out_valid,
  input  logic [11:0]       out_max_value,
  output logic              done,
  output logic [11:0]       result,
  output logic [LAT_W-1:0]  latency,
  output logic              timeout,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [LAT_W-1:0] cnt;

  logic [5:0]  mem_a1 [7];
  logic [5:0]  mem_a2 [7];
  logic [11:0] mem_b  [7];

  logic       wr_ok;
  logic [5:0] obj_a1;
  logic [5:0] obj_a2;

`ifdef LP_TX_TIMEOUT_EN
  localparam logic [LAT_W-1:0] WMAX = LAT_W'(WAIT_MAX);
`endif

  assign wr_ok = cfg_we && (state == IDLE) && (cfg_addr != 3'd7);

  // Entry 0 goes out on the start edge itself, so a same-cycle write must bypass the register file.
  assign obj_a1 = (wr_ok && cfg_addr == 3'd0) ? cfg_a1 : mem_a1[0];
  assign obj_a2 = (wr_ok && cfg_addr == 3'd0) ? cfg_a2 : mem_a2[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      cnt       <= '0;
      busy      <= 1'b0;
      in_valid  <= 1'b0;
      in_a1     <= '0;
      in_a2     <= '0;
      in_b      <= '0;
      done      <= 1'b0;
      result    <= '0;
      latency   <= '0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < 7; i++) begin
        mem_a1[i] <= '0;
        mem_a2[i] <= '0;
        mem_b[i]  <= '0;
      end
    end else begin
      done <= 1'b0;

      if (wr_ok) begin
        mem_a1[cfg_addr] <= cfg_a1;
        mem_a2[cfg_addr] <= cfg_a2;
        mem_b[cfg_addr]  <= cfg_b;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state     <= SEND;
            busy      <= 1'b1;
            proto_err <= 1'b0;
            in_valid  <= 1'b1;
            in_a1     <= obj_a1;
            in_a2     <= obj_a2;
            in_b      <= '0;
            idx       <= 3'd1;
          end
        end

        SEND: begin
          if (idx == 3'd7) begin
            state    <= WAIT;
            in_valid <= 1'b0;
            in_a1    <= '0;
            in_a2    <= '0;
            in_b     <= '0;
            cnt      <= {{(LAT_W-1){1'b0}}, 1'b1};
          end else begin
            in_a1 <= mem_a1[idx];
            in_a2 <= mem_a2[idx];
            in_b  <= mem_b[idx];
            idx   <= idx + 3'd1;
          end
        end

        WAIT: begin
          if (out_valid) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= out_max_value;
            latency <= cnt;
            timeout <= 1'b0;
          end
`ifdef LP_TX_TIMEOUT_EN
          else if (cnt >= WMAX) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= 12'h800;
            latency <= WMAX;
            timeout <= 1'b1;
          end
`endif
          else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // A stray result strobe outside WAIT is flagged; placed last so it wins over a start clear.
      if (out_valid && state != WAIT) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule
